// File: rtl/playseq_controle_preview_if.sv
// Handshake and data bundle between the PlaySeq control unit / sequence
// memory (master) and the preview sequencer (slave).
//   iniciar, parar       : start request and abort from the control unit
//   limite               : index of the last play to show
//   dado_memoria         : sequence memory content at endereco
//   endereco, leds       : memory address and one-hot play shown
//   ocupado, pronto      : busy flag and end-of-preview pulse
//   db_estado            : state code for the debug display
interface playseq_controle_preview_if;
    logic       iniciar;
    logic       parar;
    logic [3:0] limite;
    logic [3:0] dado_memoria;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        output iniciar, parar, limite, dado_memoria,
        input  endereco, leds, ocupado, pronto, db_estado
    );

    modport slave (
        input  iniciar, parar, limite, dado_memoria,
        output endereco, leds, ocupado, pronto, db_estado
    );
endinterface

// File: rtl/playseq_controle_preview.sv
// PlaySeq preview sequencer: walks the sequence memory from address 0 up to
// a latched limit, showing each stored play on the LEDs for T_ACESO cycles
// followed by a blank gap of T_APAGADO cycles, then pulses pronto.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of playseq_controle_preview_if
module playseq_controle_preview #(
    parameter int unsigned T_ACESO   = 500,
    parameter int unsigned T_APAGADO = 250
) (
    input  logic                           clock,
    input  logic                           reset,
    playseq_controle_preview_if.slave      bus
);

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned PLAY_W  = 4;

    typedef enum logic [3:0] {
        S_INICIAL = 4'd0,
        S_CARREGA = 4'd1,
        S_ACESO   = 4'd2,
        S_APAGADO = 4'd3,
        S_PROXIMO = 4'd4,
        S_FIM     = 4'd5
    } state_t;

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   endereco_q, endereco_d;
    logic [PLAY_W-1:0]   leds_q,     leds_d;
    logic [TIMER_W-1:0]  timer_q,    timer_d;
    logic [ADDR_W-1:0]   limite_q,   limite_d;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_INICIAL;
            endereco_q <= '0;
            leds_q     <= '0;
            timer_q    <= '0;
            limite_q   <= '0;
        end else begin
            state_q    <= state_d;
            endereco_q <= endereco_d;
            leds_q     <= leds_d;
            timer_q    <= timer_d;
            limite_q   <= limite_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        endereco_d = endereco_q;
        leds_d     = leds_q;
        timer_d    = timer_q;
        limite_d   = limite_q;

        unique case (state_q)
            S_INICIAL: begin
                leds_d = '0;
                if (bus.iniciar) begin
                    state_d    = S_CARREGA;
                    endereco_d = '0;
                    limite_d   = bus.limite;
                end
            end
            // One cycle so the memory output settles for the new address.
            S_CARREGA: begin
                leds_d  = bus.dado_memoria;
                timer_d = '0;
                state_d = S_ACESO;
            end
            S_ACESO: begin
                if (timer_q == TIMER_W'(T_ACESO - 1)) begin
                    leds_d  = '0;
                    timer_d = '0;
                    state_d = S_APAGADO;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_APAGADO: begin
                if (timer_q == TIMER_W'(T_APAGADO - 1)) begin
                    timer_d = '0;
                    state_d = (endereco_q == limite_q) ? S_FIM : S_PROXIMO;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_PROXIMO: begin
                endereco_d = endereco_q + ADDR_W'(1);
                state_d    = S_CARREGA;
            end
            S_FIM: begin
                state_d = S_INICIAL;
            end
            default: begin
                state_d = S_INICIAL;
            end
        endcase

        // Abort wins over every transition above, outside INICIAL only.
        if (bus.parar && (state_q != S_INICIAL)) begin
            state_d    = S_INICIAL;
            leds_d     = '0;
            timer_d    = '0;
            endereco_d = endereco_q;
            limite_d   = limite_q;
        end
    end

    // Moore outputs decoded from the state register; data outputs are flops.
    assign bus.endereco  = endereco_q;
    assign bus.leds      = leds_q;
    assign bus.ocupado   = (state_q != S_INICIAL);
    assign bus.pronto    = (state_q == S_FIM);
    assign bus.db_estado = state_q;

endmodule
